resistive_n_way_mixer: RTL and testbench

RESISTIVE_N_WAY_MIXER -- requirements
Module: resistive_n_way_mixer

---
 rtl/resistive_n_way_mixer.sv | 183 ++++++++++++++++++
 tb/tb_resistive_n_way_mixer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/resistive_n_way_mixer.sv
// Resistive N-way audio mixer: weights each channel by its conductance
// share and sums the channels sequentially through one multiplier.
// Ports: clk, I_RSTn (async, active-low), audio_clk_en (sample strobe),
//   inputs[CHANNELS] (signed 16), out (signed 16, held),
//   out_valid (1-cycle pulse), busy (mix running),
//   overrun (sticky: strobe seen while busy).
// Optional: define RESISTIVE_MIXER_MUTE_EN to add mute[CHANNELS];
//   a muted channel is treated as grounded and its weight is kept.
`timescale 1ns/1ps

module resistive_n_way_mixer #(
  parameter int          CHANNELS = 4,
  parameter int unsigned R0 = 10000,
  parameter int unsigned R1 = 10000,
  parameter int unsigned R2 = 10000,
  parameter int unsigned R3 = 10000,
  parameter int unsigned R4 = 10000,
  parameter int unsigned R5 = 10000,
  parameter int unsigned R6 = 10000,
  parameter int unsigned R7 = 10000
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic signed [15:0] inputs [CHANNELS-1:0],
`ifdef RESISTIVE_MIXER_MUTE_EN
  input  logic [CHANNELS-1:0] mute,
`endif
  output logic signed [15:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int IW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int WB = CHANNELS * 17;

  function automatic logic [63:0] r_of(input int i);
    case (i)
      0:       return 64'(R0);
      1:       return 64'(R1);
      2:       return 64'(R2);
      3:       return 64'(R3);
      4:       return 64'(R4);
      5:       return 64'(R5);
      6:       return 64'(R6);
      default: return 64'(R7);
    endcase
  endfunction

  // Conductance G = 2^32/R; weight = 2^16 * G / sum(G), floored.
  function automatic logic [WB-1:0] build_wtab();
    logic [63:0]   g [CHANNELS];
    logic [63:0]   sum;
    logic [WB-1:0] t;
    t   = '0;
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      g[i] = (64'd1 << 32) / r_of(i);
      sum  = sum + g[i];
    end
    for (int i = 0; i < CHANNELS; i++) begin
      t[i*17 +: 17] = 17'((g[i] << 16) / sum);
    end
    return t;
  endfunction

  localparam logic [WB-1:0] WTAB = build_wtab();

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [36:0]    acc_q, acc_d;
  logic signed [15:0]    out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic signed [15:0]    snap_q [CHANNELS-1:0];
  logic                  start;

  logic [16:0]           w_sel;
  logic signed [15:0]    samp;
  logic signed [33:0]    w_ext, s_ext, prod;

  assign busy      = (state_q != S_IDLE);
  assign start     = audio_clk_en && !busy;
  assign out       = out_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

  assign w_sel = WTAB[int'(idx_q)*17 +: 17];

`ifdef RESISTIVE_MIXER_MUTE_EN
  logic [CHANNELS-1:0] mute_q;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      mute_q <= '0;
    end else if (start) begin
      mute_q <= mute;
    end
  end

  assign samp = mute_q[idx_q] ? 16'sd0 : snap_q[idx_q];
`else
  assign samp = snap_q[idx_q];
`endif

  // Zero-extend the unsigned weight so the product stays signed.
  assign w_ext = 34'($signed({1'b0, w_sel}));
  assign s_ext = 34'(samp);
  assign prod  = w_ext * s_ext;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        snap_q[i] <= '0;
      end
    end else if (start) begin
      snap_q <= inputs;
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q | (audio_clk_en & busy);
    unique case (state_q)
      S_IDLE: begin
        if (audio_clk_en) begin
          state_d = S_ACC;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_ACC: begin
        acc_d = acc_q + 37'(prod);
        // Park idx at 0 after the last channel so it never
        // points past the snapshot bank.
        if (idx_q == IW'(CHANNELS-1)) begin
          idx_d   = '0;
          state_d = S_OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_OUT: begin
        out_d   = 16'(acc_q >>> 16);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_resistive_n_way_mixer.sv
// Directed bench for resistive_n_way_mixer: several instances cover
// 2- and 4-channel mixes, unequal resistors, overrun, reset and mute.
`timescale 1ns/1ps

module tb_resistive_n_way_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic               s2, s4, sr;
  logic signed [15:0] in2 [1:0];
  logic signed [15:0] in4 [3:0];
  logic signed [15:0] inr [1:0];
  logic signed [15:0] o2, o4, orr;
  logic               v2, b2, ov2;
  logic               v4, b4, ov4;
  logic               vr, br, ovr;

  int checks   = 0;
  int failures = 0;
  int lat;
  int nv;

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  resistive_n_way_mixer #(.CHANNELS(2)) dut2 (
    .clk(clk), .I_RSTn(rstn), .audio_clk_en(s2),
    .inputs(in2),
`ifdef RESISTIVE_MIXER_MUTE_EN
    .mute(2'b00),
`endif
    .out(o2), .out_valid(v2), .busy(b2), .overrun(ov2)
  );

  resistive_n_way_mixer #(.CHANNELS(4)) dut4 (
    .clk(clk), .I_RSTn(rstn), .audio_clk_en(s4),
    .inputs(in4),
`ifdef RESISTIVE_MIXER_MUTE_EN
    .mute(4'b0000),
`endif
    .out(o4), .out_valid(v4), .busy(b4), .overrun(ov4)
  );

  resistive_n_way_mixer #(
    .CHANNELS(2), .R0(10000), .R1(30000)
  ) dutr (
    .clk(clk), .I_RSTn(rstn), .audio_clk_en(sr),
    .inputs(inr),
`ifdef RESISTIVE_MIXER_MUTE_EN
    .mute(2'b00),
`endif
    .out(orr), .out_valid(vr), .busy(br), .overrun(ovr)
  );

`ifdef RESISTIVE_MIXER_MUTE_EN
  logic               sm;
  logic signed [15:0] inm [1:0];
  logic [1:0]         mm;
  logic signed [15:0] om;
  logic               vm, bm, ovm;

  resistive_n_way_mixer #(.CHANNELS(2)) dutm (
    .clk(clk), .I_RSTn(rstn), .audio_clk_en(sm),
    .inputs(inm), .mute(mm),
    .out(om), .out_valid(vm), .busy(bm), .overrun(ovm)
  );
`endif

  task automatic run4(input logic signed [15:0] val,
                      input int exp, input string tag);
    for (int i = 0; i < 4; i++) in4[i] = val;
    s4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s4  = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (v4 && lat == 0) lat = k;
    end
    check({tag, "_lat"}, lat, 5);
    check({tag, "_out"}, int'(o4), exp);
  endtask

  initial begin
    rstn = 1'b0;
    s2 = 1'b0; s4 = 1'b0; sr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in2[i] = '0; inr[i] = '0;
    end
    for (int i = 0; i < 4; i++) in4[i] = '0;
`ifdef RESISTIVE_MIXER_MUTE_EN
    sm = 1'b0; mm = 2'b00;
    inm[0] = '0; inm[1] = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_out", int'(o2), 0);
    check("rst_valid", int'(v2), 0);
    check("rst_busy", int'(b2), 0);
    check("rst_ovr", int'(ov2), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Equal weights 32768: (1000+3000)/2 = 2000 at E+3.
    in2[0] = 16'sd1000; in2[1] = 16'sd3000;
    s2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s2 = 1'b0;
    check("a_busyE", int'(b2), 1);
    check("a_validE", int'(v2), 0);
    @(negedge clk);
    check("a_busyE1", int'(b2), 1);
    @(negedge clk);
    check("a_busyE2", int'(b2), 1);
    check("a_validE2", int'(v2), 0);
    @(negedge clk);
    check("a_validE3", int'(v2), 1);
    check("a_outE3", int'(o2), 2000);
    check("a_busyE3", int'(b2), 0);
    @(negedge clk);
    check("a_validE4", int'(v2), 0);
    check("a_hold", int'(o2), 2000);
    check("a_ovr", int'(ov2), 0);

    // Four equal weights of 16384: full-scale in gives full-scale out.
    run4(16'sd32767, 32767, "b_max");
    run4(-16'sd32768, -32768, "b_min");

    // R1=30000: W={49152,16383}; 4000*49152>>16 = 3000.
    // A strobe at E+3 is still ignored and sets overrun.
    inr[0] = 16'sd4000; inr[1] = 16'sd0;
    sr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("c_ovr_pre", int'(ovr), 0);
    sr = 1'b1;
    @(negedge clk);
    sr = 1'b0;
    check("c_valid", int'(vr), 1);
    check("c_out", int'(orr), 3000);
    check("c_ovr_edge", int'(ovr), 1);
    check("c_busy", int'(br), 0);
    @(negedge clk);
    check("c_busy_after", int'(br), 0);
    check("c_valid_after", int'(vr), 0);

    // Second strobe at E+1 with changed inputs: ignored, overrun.
    // Mix uses first snapshot {2000,6000} -> 4000.
    in2[0] = 16'sd2000; in2[1] = 16'sd6000;
    s2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in2[0] = 16'sd0; in2[1] = 16'sd0;
    @(posedge clk);
    @(negedge clk);
    s2 = 1'b0;
    check("d_ovr", int'(ov2), 1);
    nv  = 0;
    lat = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (v2) begin
        nv++;
        lat = k;
      end
    end
    check("d_nvalid", nv, 1);
    check("d_lat", lat, 3);
    check("d_out", int'(o2), 4000);

    // Reset at E+1 aborts the mix and clears everything at once.
    in2[0] = 16'sd1000; in2[1] = 16'sd3000;
    s2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s2 = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("e_out", int'(o2), 0);
    check("e_busy", int'(b2), 0);
    check("e_ovr", int'(ov2), 0);
    check("e_valid", int'(v2), 0);
    @(negedge clk);
    rstn = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (v2) nv++;
    end
    check("e_novalid", nv, 0);

    // First strobe after release is a normal mix.
    s2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s2  = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (v2 && lat == 0) lat = k;
    end
    check("f_lat", lat, 3);
    check("f_out", int'(o2), 2000);

`ifdef RESISTIVE_MIXER_MUTE_EN
    // Channel 1 grounded, weights unchanged: 1000*32768>>16 = 500.
    inm[0] = 16'sd1000; inm[1] = 16'sd3000;
    mm = 2'b10;
    sm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sm  = 1'b0;
    mm  = 2'b00;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (vm && lat == 0) lat = k;
    end
    check("g_lat", lat, 3);
    check("g_out", int'(om), 500);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
